// File: rtl/voter_display_scan.sv
// ---------------------------------------------------------------------------
// voter_display_scan
//
// Time-multiplexed seven-segment driver for the N-voter result panel.
// A load strobe captures a binary vote count and a pass/fail result. A
// sequential double-dabble engine converts the count to four BCD digits.
// The finished result is committed atomically into display shadow registers.
// The left bank shows the count in decimal with leading-zero blanking, or the
// error glyph on every digit when the count exceeds VOTERS. The right bank
// spells PASS / FAIL. With fewer than four digits it shows only P / F.
//
// Parameters
//   VOTERS       number of voters (1..9999), sets count width W
//   DIGITS       digits scanned per bank (1..4)
//   DIV          clk cycles per scan tick (>= 2)
//   BLINK_TICKS  scan ticks per blink half-period (blink build only)
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   load          one-cycle strobe, captures count and res
//   count [W-1:0] vote count, binary
//   res           1 = pass, 0 = fail
//   a_to_g_left   left bank segments {a,b,c,d,e,f,g,dp}, active-high
//   a_to_g_right  right bank segments, same encoding
//   leftseg       left digit enables, one-hot, bit0 = rightmost digit
//   rightseg      right digit enables, same indexing
//
// Optional feature macro: VOTER_DISP_BLINK_EN
//   When defined, a committed result that differs from the displayed one
//   blinks the right bank for three off/on cycles of BLINK_TICKS ticks each.
// ---------------------------------------------------------------------------
module voter_display_scan #(
    parameter int VOTERS      = 5,
    parameter int DIGITS      = 4,
    parameter int DIV         = 100000,
    parameter int BLINK_TICKS = 256,
    localparam int W          = $clog2(VOTERS + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] count,
    input  logic         res,
    output logic [7:0]   a_to_g_left,
    output logic [7:0]   a_to_g_right,
    output logic [3:0]   leftseg,
    output logic [3:0]   rightseg
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [4:0] ITER_LAST = 5'(W - 1);

    localparam logic [7:0] G_BLANK = 8'b00000000;
    localparam logic [7:0] G_ERR   = 8'b00000001;
    localparam logic [7:0] G_P     = 8'b11001110;
    localparam logic [7:0] G_A     = 8'b11101110;
    localparam logic [7:0] G_S     = 8'b10110110;
    localparam logic [7:0] G_F     = 8'b10001110;
    localparam logic [7:0] G_I     = 8'b00001100;
    localparam logic [7:0] G_L     = 8'b00011100;
    localparam logic [7:0] G_ZERO  = 8'b11111100;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } conv_state_t;

    conv_state_t state, state_next;
    logic        commit;

    logic [W-1:0] cap_count;
    logic         cap_res;
    logic [W-1:0] bin_q;
    logic [15:0]  bcd_q;
    logic [15:0]  bcd_adj;
    logic [4:0]   iter_q;
    logic [31:0]  cap_wide;
    logic         cap_over;

    logic [15:0]  sh_bcd;
    logic         sh_over;
    logic         sh_res;

    logic [DW-1:0] div_q;
    logic          tick;
    logic [1:0]    idx_q;
    logic [1:0]    idx_next;

    logic [3:0]    en_next;
    logic [7:0]    left_next;
    logic [7:0]    right_next;
    logic          lead_blank;
    logic          right_off;

    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'b11111100;
            4'd1:    g = 8'b01100000;
            4'd2:    g = 8'b11011010;
            4'd3:    g = 8'b11110010;
            4'd4:    g = 8'b01100110;
            4'd5:    g = 8'b10110110;
            4'd6:    g = 8'b10111110;
            4'd7:    g = 8'b11100000;
            4'd8:    g = 8'b11111110;
            4'd9:    g = 8'b11110110;
            default: g = G_ERR;
        endcase
        return g;
    endfunction

    // Converter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Converter next state. A load from any state restarts the conversion;
    // when it lands in COMMIT the commit still happens in that same cycle, so
    // the previous result is not lost.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            IDLE: state_next = IDLE;
            CONV: begin
                if (iter_q == ITER_LAST) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            state_next = CONV;
        end
    end

    // Add-3 correction for every BCD nibble that is 5 or more, applied before
    // each shift of the double-dabble.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign cap_wide = 32'(cap_count);
    assign cap_over = (cap_wide > 32'(VOTERS));

    // Capture and double-dabble datapath. The original count is kept apart
    // from the shifting copy so the overrange test sees the real value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_count <= '0;
            cap_res   <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
        end else if (load) begin
            cap_count <= count;
            cap_res   <= res;
            bin_q     <= count;
            bcd_q     <= '0;
            iter_q    <= '0;
        end else if (state == CONV) begin
            {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
            iter_q         <= iter_q + 5'd1;
        end
    end

    // Display shadow registers, written in one cycle so the panel never shows
    // a half-updated result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_bcd  <= '0;
            sh_over <= 1'b0;
            sh_res  <= 1'b0;
        end else if (commit) begin
            sh_bcd  <= bcd_q;
            sh_over <= cap_over;
            sh_res  <= cap_res;
        end
    end

    assign tick = (div_q == DW'(DIV - 1));

    always_comb begin
        idx_next = idx_q;
        if (tick) begin
            idx_next = (idx_q == 2'(DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
        end
    end

    // Scan divider and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= 2'd0;
        end else begin
            div_q <= tick ? '0 : div_q + DW'(1);
            idx_q <= idx_next;
        end
    end

`ifdef VOTER_DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic          blink_active;
    logic [2:0]    half_q;
    logic [BW-1:0] btick_q;

    // Blink sequencer: six half-periods of BLINK_TICKS scan ticks, even
    // half-periods are "off". A fresh res change restarts it from the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_active <= 1'b0;
            half_q       <= 3'd0;
            btick_q      <= '0;
        end else if (commit && (cap_res != sh_res)) begin
            blink_active <= 1'b1;
            half_q       <= 3'd0;
            btick_q      <= '0;
        end else if (blink_active && tick) begin
            if (btick_q == BW'(BLINK_TICKS - 1)) begin
                btick_q <= '0;
                if (half_q == 3'd5) begin
                    blink_active <= 1'b0;
                end else begin
                    half_q <= half_q + 3'd1;
                end
            end else begin
                btick_q <= btick_q + BW'(1);
            end
        end
    end

    assign right_off = blink_active & ~half_q[0];
`else
    // Without blinking the right bank is only ever forced off by a
    // meaningless (non-positive) blink period, which never occurs for
    // legal settings.
    assign right_off = (BLINK_TICKS < 1);
`endif

    // Glyph selection for the digit that becomes active at the next edge, so
    // enables and segments switch together.
    always_comb begin
        en_next    = 4'b0001 << idx_next;
        lead_blank = 1'b0;
        case (idx_next)
            2'd1:    lead_blank = (sh_bcd[15:4] == 12'd0);
            2'd2:    lead_blank = (sh_bcd[15:8] == 8'd0);
            2'd3:    lead_blank = (sh_bcd[15:12] == 4'd0);
            default: lead_blank = 1'b0;
        endcase

        if (sh_over) begin
            left_next = G_ERR;
        end else if (lead_blank) begin
            left_next = G_BLANK;
        end else begin
            left_next = digit_glyph(sh_bcd[4*idx_next +: 4]);
        end

        right_next = G_BLANK;
        if (DIGITS == 4) begin
            case (idx_next)
                2'd3:    right_next = sh_res ? G_P : G_F;
                2'd2:    right_next = G_A;
                2'd1:    right_next = sh_res ? G_S : G_I;
                default: right_next = sh_res ? G_S : G_L;
            endcase
        end else if (idx_next == 2'd0) begin
            right_next = sh_res ? G_P : G_F;
        end
    end

    // Registered segment and enable outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leftseg      <= 4'b0001;
            rightseg     <= 4'b0001;
            a_to_g_left  <= G_ZERO;
            a_to_g_right <= (DIGITS == 4) ? G_L : G_F;
        end else begin
            leftseg      <= en_next;
            rightseg     <= en_next;
            a_to_g_left  <= left_next;
            a_to_g_right <= right_off ? G_BLANK : right_next;
        end
    end

endmodule

// File: tb/tb_voter_display_scan.sv
// ---------------------------------------------------------------------------
// tb_voter_display_scan
//
// Self-checking bench for voter_display_scan with VOTERS=300, DIGITS=4 and
// DIV=4. A reference model tracks which count/result should be on the panel
// from load timing rules, and derives every expected glyph from decimal
// arithmetic and the PASS/FAIL words.
// ---------------------------------------------------------------------------
module tb_voter_display_scan;

    localparam int VOTERS = 300;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int W      = $clog2(VOTERS + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] count = '0;
    logic         res = 1'b0;
    logic [7:0]   a_to_g_left;
    logic [7:0]   a_to_g_right;
    logic [3:0]   leftseg;
    logic [3:0]   rightseg;

    int errors = 0;
    int checks = 0;

    voter_display_scan #(
        .VOTERS(VOTERS),
        .DIGITS(DIGITS),
        .DIV(DIV),
        .BLINK_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .count(count),
        .res(res),
        .a_to_g_left(a_to_g_left),
        .a_to_g_right(a_to_g_right),
        .leftseg(leftseg),
        .rightseg(rightseg)
    );

    always #5 clk = ~clk;

    wire [23:0] outs = {leftseg, rightseg, a_to_g_left, a_to_g_right};

    // Reference model: which value is visible, and when pending loads land.
    typedef struct {
        int vis;
        int c;
        bit r;
    } pend_t;

    pend_t q[$];
    int    cyc = 0;
    int    vis_count = 0;
    bit    vis_res = 1'b0;

    // A load becomes visible W+2 edges after it is sampled. A newer load
    // discards any older one whose commit edge has not yet been reached.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0;
            vis_count = 0;
            vis_res = 1'b0;
            q.delete();
        end else begin
            cyc++;
            if (q.size() > 0 && q[0].vis == cyc) begin
                vis_count = q[0].c;
                vis_res = q[0].r;
                void'(q.pop_front());
            end
            if (load) begin
                while (q.size() > 0 && q[$].vis > cyc + 1) void'(q.pop_back());
                q.push_back('{cyc + W + 2, int'(count), res});
            end
        end
    end

    function automatic logic [7:0] digit_glyph(input int d);
        case (d)
            0: return 8'b11111100;
            1: return 8'b01100000;
            2: return 8'b11011010;
            3: return 8'b11110010;
            4: return 8'b01100110;
            5: return 8'b10110110;
            6: return 8'b10111110;
            7: return 8'b11100000;
            8: return 8'b11111110;
            9: return 8'b11110110;
            default: return 8'b00000001;
        endcase
    endfunction

    function automatic logic [7:0] letter_glyph(input byte ch);
        case (ch)
            "P": return 8'b11001110;
            "A": return 8'b11101110;
            "S": return 8'b10110110;
            "F": return 8'b10001110;
            "I": return 8'b00001100;
            "L": return 8'b00011100;
            default: return 8'b00000000;
        endcase
    endfunction

    function automatic logic [23:0] expected_outputs(input int c, input bit r, input int idx);
        logic [3:0] en;
        logic [7:0] l;
        logic [7:0] rg;
        string      word;
        int         p;
        en = 4'b0001 << idx;
        p = 10 ** idx;
        if (c > VOTERS) l = 8'b00000001;
        else if (idx > 0 && c < p) l = 8'b00000000;
        else l = digit_glyph((c / p) % 10);
        word = r ? "PASS" : "FAIL";
        rg = letter_glyph(word[3 - idx]);
        return {en, en, l, rg};
    endfunction

    function automatic logic [23:0] exp_now();
        return expected_outputs(vis_count, vis_res, (cyc / DIV) % DIGITS);
    endfunction

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (leftseg !== 4'b0001) begin errors++; $display("[TB] FAIL reset_leftseg got=%b exp=0001", leftseg); end
        checks++; if (rightseg !== 4'b0001) begin errors++; $display("[TB] FAIL reset_rightseg got=%b exp=0001", rightseg); end
        checks++; if (a_to_g_left !== 8'b11111100) begin errors++; $display("[TB] FAIL reset_left got=%b exp=11111100", a_to_g_left); end
        checks++; if (a_to_g_right !== 8'b00011100) begin errors++; $display("[TB] FAIL reset_right got=%b exp=00011100", a_to_g_right); end
        rst = 1'b0;
        n = 0;
        while (n < 3 * DIV && leftseg === 4'b0001) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== DIV) begin errors++; $display("[TB] FAIL first_tick_cycles got=%0d exp=%0d", n, DIV); end
        checks++; if (leftseg !== 4'b0010) begin errors++; $display("[TB] FAIL tick_leftseg got=%b exp=0010", leftseg); end
        checks++; if (rightseg !== 4'b0010) begin errors++; $display("[TB] FAIL tick_rightseg got=%b exp=0010", rightseg); end
    endtask

    task automatic test_load_basic();
        @(negedge clk);
        load = 1'b1; count = W'(3); res = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (W + 2 * DIV * DIGITS + 4) begin
            @(negedge clk);
            checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL load_basic cyc=%0d got=%h exp=%h", cyc, outs, exp_now()); end
        end
    endtask

    task automatic test_decimal();
        logic [7:0] seen [4];
        logic [7:0] want [4];
        want[0] = 8'b11100000; want[1] = 8'b11111100; want[2] = 8'b11011010; want[3] = 8'b00000000;
        for (int k = 0; k < 4; k++) seen[k] = 8'hxx;
        @(negedge clk);
        load = 1'b1; count = W'(207); res = 1'b0;
        @(negedge clk);
        load = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL decimal_wait cyc=%0d got=%h exp=%h", cyc, outs, exp_now()); end
        end
        repeat (DIV * DIGITS + 1) begin
            @(negedge clk);
            checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL decimal_scan cyc=%0d got=%h exp=%h", cyc, outs, exp_now()); end
            for (int k = 0; k < 4; k++) if (leftseg === (4'b0001 << k)) seen[k] = a_to_g_left;
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (seen[k] !== want[k]) begin errors++; $display("[TB] FAIL decimal_digit%0d got=%b exp=%b", k, seen[k], want[k]); end
        end
    endtask

    task automatic test_boundary();
        int vals [3];
        vals[0] = VOTERS; vals[1] = VOTERS + 1; vals[2] = (1 << W) - 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load = 1'b1; count = W'(vals[i]); res = i[0];
            @(negedge clk);
            load = 1'b0;
            repeat (W + 2 + DIV * DIGITS + 2) begin
                @(negedge clk);
                checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL boundary val=%0d cyc=%0d got=%h exp=%h", vals[i], cyc, outs, exp_now()); end
            end
        end
    endtask

    task automatic test_abort();
        bit saw2 = 1'b0;
        bit saw4 = 1'b0;
        @(negedge clk);
        load = 1'b1; count = W'(2); res = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        load = 1'b1; count = W'(4);
        @(negedge clk);
        load = 1'b0;
        repeat (W + 2 + 2 * DIV * DIGITS) begin
            @(negedge clk);
            checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL abort cyc=%0d got=%h exp=%h", cyc, outs, exp_now()); end
            if (leftseg === 4'b0001 && a_to_g_left === 8'b11011010) saw2 = 1'b1;
            if (leftseg === 4'b0001 && a_to_g_left === 8'b01100110) saw4 = 1'b1;
        end
        checks++; if (saw2 !== 1'b0) begin errors++; $display("[TB] FAIL abort_saw2 got=%0b exp=0", saw2); end
        checks++; if (saw4 !== 1'b1) begin errors++; $display("[TB] FAIL abort_final4 got=%0b exp=1", saw4); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        load = 1'b1; count = W'(58); res = 1'b0;
        @(negedge clk);
        load = 1'b0;
        repeat (W) @(negedge clk);
        load = 1'b1; count = W'(91); res = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (W + 2 + DIV * DIGITS + 2) begin
            @(negedge clk);
            checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, outs, exp_now()); end
        end
    endtask

    task automatic test_random();
        int gap;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, outs, exp_now()); end
            load = 1'b1;
            count = W'($urandom_range((1 << W) - 1, 0));
            res = 1'($urandom_range(1, 0));
            gap = $urandom_range(W + 6, 0);
            @(negedge clk);
            load = 1'b0;
            checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, outs, exp_now()); end
            repeat (gap) begin
                @(negedge clk);
                checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, outs, exp_now()); end
            end
        end
        repeat (W + 2 + DIV * DIGITS) begin
            @(negedge clk);
            checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL random_settle cyc=%0d got=%h exp=%h", cyc, outs, exp_now()); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        load = 1'b1; count = W'(123); res = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (outs !== {4'b0001, 4'b0001, 8'b11111100, 8'b00011100}) begin errors++; $display("[TB] FAIL reset_mid_async got=%h exp=%h", outs, {4'b0001, 4'b0001, 8'b11111100, 8'b00011100}); end
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2 + 2 * DIV * DIGITS) begin
            @(negedge clk);
            checks++; if (outs !== exp_now()) begin errors++; $display("[TB] FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, outs, exp_now()); end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_decimal();
        test_boundary();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/voter_display_scan.md
# voter_display_scan

Parametrised, time-multiplexed seven-segment driver for the N-voter result panel. It latches a vote count and a pass/fail result on a load strobe and converts the count to BCD with a sequential double-dabble engine. It scans up to four digits per bank, showing the count in decimal with leading-zero blanking on the left bank and "PASS"/"FAIL" on the right bank. It sits between the vote tally logic and the board's two segment banks.

## Interface
- VOTERS, 5, number of voters; legal range 1..9999; W = $clog2(VOTERS+1)
- DIGITS, 4, digits scanned per bank; legal range 1..4
- DIV, 100000, clk cycles per scan tick (digit dwell); must be ≥ 2
- BLINK_TICKS, 256, scan ticks per blink half-period (used only with blink enabled)

- clk  in  1  system clock (one clock domain)
- rst  in  1  asynchronous, active-high reset
- load  in  1  one-cycle strobe; captures count and res
- count  in  W  vote count, binary
- res  in  1  result; 1 = pass, 0 = fail
- a_to_g_left  out  8  left bank segments {a,b,c,d,e,f,g,dp}, active-high
- a_to_g_right  out  8  right bank segments, same encoding
- leftseg  out  4  left digit enables, one-hot, active-high; bit0 = rightmost digit
- rightseg  out  4  right digit enables, same indexing

## Operation
- Glyphs: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110; P=11001110, A=11101110, S=10110110, F=10001110, I=00001100, L=00011100; blank=00000000; error=00000001.
- Capture: on load, register count and res, then start conversion. Clock W iterations of shift-add-3 over 16 BCD bits.
- Converter FSM: IDLE -> CONV (W cycles, iteration counter) -> COMMIT (1 cycle) -> IDLE. COMMIT writes the BCD digits, the overrange flag (count > VOTERS), and res into the display shadow registers atomically.
- Left bank, digit k: the BCD digit k. Blank if k>0 and all digits ≥ k are zero (ones digit always shown). If overrange, every active digit shows the error glyph.
- Right bank:
  - DIGITS=4: bits 3..0 spell P,A,S,S or F,A,I,L.
  - DIGITS<4: digit 0 shows P or F; other digits are blank.
- Scan: a divider counts 0..DIV-1 and pulses a tick at DIV-1. On each tick, the index advances 0..DIGITS-1 and wraps to 0.
- leftseg and rightseg are both one-hot at the index. Enable bits ≥ DIGITS are always 0.
- Segment outputs are registered and update in the same cycle as the enables, so there is no ghosting skew.

## Timing
- Reset (async): FSM IDLE, divider 0, index 0, shadow = count 0, res 0, no overrange.
- Outputs after reset: leftseg=rightseg=0001, a_to_g_left=11111100. a_to_g_right=00011100 (L) for DIGITS=4, 10001110 (F) otherwise.
- Load latency: load in cycle n -> shadow updated at the end of cycle n+W+1. Displayed segments change at the next output register update, which follows the shadow by one cycle and does not wait for a tick.
- load during CONV: abort, recapture, restart. The shadow keeps its old value until the new COMMIT.
- load in the COMMIT cycle: COMMIT completes, then the new conversion starts.
- Scan period = DIV×DIGITS cycles. DIGITS=1: the index stays 0 and the enables stay 0001.
- Reset mid-conversion: return to reset state immediately; the pending value is discarded.

## Configuration
- VOTER_DISP_BLINK_EN defined:
  - A COMMIT whose res differs from the shadow res starts a blink sequence.
  - The right bank segments are forced blank during "off" half-periods of BLINK_TICKS scan ticks.
  - The sequence is 3 off/on cycles (6 half-periods, starting with off), then steady.
  - A new res change restarts the sequence. rightseg keeps scanning.
- Undefined: no blink logic is synthesised, and the right bank always shows the shadow result.

## Test plan
- Reset release, VOTERS=5, DIGITS=4 -> leftseg=0001, a_to_g_left=11111100; rightseg=0001, a_to_g_right=00011100; after one tick, both enables = 0010.
- load count=3, res=1 -> commit after W+1 cycles; digit 0 left=11110010; right digits 3..0 = P,A,S,S; left digits 1..3 blank.
- VOTERS=300, load count=207 -> left digits 2,1,0 = 11011010, 11111100, 11100000; digit 3 blank.
- VOTERS=5, load count=6 (overrange) -> all four left digits = 00000001; right bank unchanged apart from res.
- load count=2, then load count=4 two cycles later (mid-CONV) -> shadow never shows 2; final digit 0 = 01100110.
- VOTER_DISP_BLINK_EN, DIV=4, BLINK_TICKS=2, res 0->1 -> right segments blank for 8 cycles, on for 8, for 3 cycles total, then steady P/A/S/S; rst mid-blink -> immediate FAIL display, no blink.
